// File: rtl/shift_reg_tx_ctrl_if.sv
// shift_reg_tx_ctrl_if: byte valid/ready handshake between a producer (master) and the tx controller (slave)
//   in_data  byte offered by the producer
//   in_valid producer has a byte
//   in_ready controller can accept a byte
interface shift_reg_tx_ctrl_if;
  logic [7:0] in_data;
  logic in_valid;
  logic in_ready;
  modport master(output in_data, in_valid, input in_ready);
  modport slave(input in_data, in_valid, output in_ready);
endinterface

// File: rtl/shift_reg_tx_ctrl.sv
// shift_reg_tx_ctrl: sequences an external 8-bit load/shift-right register to send a byte LSB-first, each bit held DIV clocks
//   clk, rst_n  clock, async active-low reset
//   up          byte handshake (slave side of shift_reg_tx_ctrl_if)
//   abort       terminate the current byte (sync)
//   sr_s/sr_pdata/sr_sin  register controls: 1 = load sr_pdata, 0 = shift right with sr_sin into Q[7]
//   sr_q        register contents
//   ser_out/ser_valid     serial bit (sr_q[0]) and its qualifier
//   busy/done   not idle / one-cycle end-of-byte pulse
module shift_reg_tx_ctrl #(
  parameter int unsigned DIV = 1,
  parameter logic FILL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  shift_reg_tx_ctrl_if.slave up,
  input  logic abort,
  output logic sr_s,
  output logic [7:0] sr_pdata,
  output logic sr_sin,
  input  logic [7:0] sr_q,
  output logic ser_out,
  output logic ser_valid,
  output logic busy,
  output logic done
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  logic [1:0] state;
  logic [7:0] byte_q;
  logic [2:0] bit_cnt;
  logic [7:0] div_cnt;
  logic hold;
  logic accept;
  assign hold = div_cnt != 8'(DIV - 1);
  assign up.in_ready = rst_n && state == IDLE && !abort;
  assign accept = up.in_valid && up.in_ready;
  assign sr_s = state == LOAD || (state == SHIFT && hold);
  assign sr_pdata = state == LOAD ? byte_q : state == SHIFT ? sr_q : 8'h00;
  assign sr_sin = FILL;
  assign ser_out = sr_q[0];
  assign ser_valid = state == SHIFT;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      byte_q <= 8'h00;
      bit_cnt <= 3'd0;
      div_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          byte_q <= up.in_data;
          state <= LOAD;
        end
        LOAD: begin
          bit_cnt <= 3'd0;
          div_cnt <= 8'd0;
          state <= abort ? IDLE : SHIFT;
        end
        SHIFT: if (abort) begin
          bit_cnt <= 3'd0;
          div_cnt <= 8'd0;
          state <= IDLE;
        end else if (hold) begin
          div_cnt <= div_cnt + 8'd1;
        end else begin
          div_cnt <= 8'd0;
          bit_cnt <= bit_cnt + 3'd1;
          state <= bit_cnt == 3'd7 ? DONE : SHIFT;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
